// File: rtl/id_ex_skid_stage.sv
// id_ex_skid_stage: elastic ID/EX pipeline register with a 2-entry skid buffer.
// The main entry drives out_*. The skid entry catches the one instruction that
// arrives in the cycle execute first stalls. This lets in_ready come straight
// from a register while the stage still sustains one instruction per cycle.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   flush           drop held and incoming instructions (redirect from EX)
//   in_valid/ready  upstream handshake; in_ready == !skid_valid (registered)
//   in_*            decoder control bundle plus operand/PC/immediate payload
//   out_valid/ready downstream handshake; out_valid == main entry valid
//   out_*           payload of the main entry; side-effect ctrl bits are 0 on a bubble
//   stall_cnt       saturating count of cycles with out_valid && !out_ready
module id_ex_skid_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [13:0]      in_ctrl,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_rd1,
    input  logic [XLEN-1:0]  in_rd2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [4:0]       in_rd,
    input  logic [2:0]       in_funct3,
    input  logic             in_funct7b5,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [13:0]      out_ctrl,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_rd1,
    output logic [XLEN-1:0]  out_rd2,
    output logic [XLEN-1:0]  out_imm,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [2:0]       out_funct3,
    output logic             out_funct7b5,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic [13:0]     ctrl;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic            funct7b5;
    } payload_t;

    // RegWrite, MemWrite, Branch, Jump: must never leak out of a bubble
    localparam logic [13:0]      SIDE_MASK = 14'h2049;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    payload_t         main_q;
    payload_t         skid_q;
    payload_t         in_pl;
    logic             main_valid;
    logic             skid_valid;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             in_xfer;
    logic             load_main;

    assign in_pl = '{ctrl: in_ctrl, pc: in_pc, rd1: in_rd1, rd2: in_rd2, imm: in_imm,
                     rs1: in_rs1, rs2: in_rs2, rd: in_rd, funct3: in_funct3,
                     funct7b5: in_funct7b5};

    // in_ready is the inverted skid-valid register. It does not depend on out_ready.
    assign in_xfer   = in_valid && !skid_valid;
    assign load_main = !main_valid || out_ready;

    // Main/skid entries and stall counter.
    // Whenever the main entry turns into a bubble, the side-effect ctrl bits in
    // the register are cleared. This keeps out_ctrl a pure register output.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid  <= 1'b0;
            skid_valid  <= 1'b0;
            main_q      <= '0;
            skid_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (flush) begin
                main_valid  <= 1'b0;
                skid_valid  <= 1'b0;
                main_q.ctrl <= main_q.ctrl & ~SIDE_MASK;
            end else if (load_main) begin
                if (skid_valid) begin
                    // Older skid entry drains first. in_ready was 0, so no new input arrives.
                    main_q     <= skid_q;
                    main_valid <= 1'b1;
                    skid_valid <= 1'b0;
                end else if (in_xfer) begin
                    main_q     <= in_pl;
                    main_valid <= 1'b1;
                end else begin
                    main_valid  <= 1'b0;
                    main_q.ctrl <= main_q.ctrl & ~SIDE_MASK;
                end
            end else if (in_xfer) begin
                skid_q     <= in_pl;
                skid_valid <= 1'b1;
            end

            if (main_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign in_ready     = !skid_valid;
    assign out_valid    = main_valid;
    assign out_ctrl     = main_q.ctrl;
    assign out_pc       = main_q.pc;
    assign out_rd1      = main_q.rd1;
    assign out_rd2      = main_q.rd2;
    assign out_imm      = main_q.imm;
    assign out_rs1      = main_q.rs1;
    assign out_rs2      = main_q.rs2;
    assign out_rd       = main_q.rd;
    assign out_funct3   = main_q.funct3;
    assign out_funct7b5 = main_q.funct7b5;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Directed bench for id_ex_skid_stage. Inputs are driven 1 ns after the rising edge.
// Outputs are checked 1 ns after the following rising edge.
module tb_id_ex_skid_stage;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [13:0]      in_ctrl, out_ctrl;
    logic [XLEN-1:0]  in_pc, in_rd1, in_rd2, in_imm, out_pc, out_rd1, out_rd2, out_imm;
    logic [4:0]       in_rs1, in_rs2, in_rd, out_rs1, out_rs2, out_rd;
    logic [2:0]       in_funct3, out_funct3;
    logic             in_funct7b5, out_funct7b5;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_skid_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_pc(in_pc), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_pc(out_pc), .out_rd1(out_rd1), .out_rd2(out_rd2),
        .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
        .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic            rst;
        logic            fl;
        logic            iv;
        logic            ordy;
        logic [31:0]     pc;
        logic            exp_valid;
        logic            exp_ready;
        logic [31:0]     exp_pc;
        logic [3:0]      exp_stall;
    } vec_t;

    vec_t vecs[$];

    // Every payload field is derived from the PC, so one PC identifies a whole instruction.
    function automatic logic [13:0] ctrl_of(input logic [31:0] pc);
        return 14'h2049 | 14'({9'd0, pc[6:2]} << 1);
    endfunction

    task automatic drive(input logic [31:0] pc);
        in_ctrl     = ctrl_of(pc);
        in_pc       = pc;
        in_rd1      = pc ^ 32'hA5A5_0000;
        in_rd2      = ~pc;
        in_imm      = pc + 32'd3;
        in_rs1      = pc[6:2];
        in_rs2      = pc[6:2] + 5'd1;
        in_rd       = pc[6:2] ^ 5'h1F;
        in_funct3   = pc[4:2];
        in_funct7b5 = pc[2];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Full payload comparison when valid, side-effect bits zero when a bubble.
    task automatic chk_out(input string tag, input logic ev, input logic [31:0] epc);
        chk({tag, " out_valid"}, 64'(out_valid), 64'(ev));
        if (ev) begin
            chk({tag, " out_pc"}, 64'(out_pc), 64'(epc));
            chk({tag, " payload"},
                64'({out_ctrl, out_rd1 ^ out_rd2, out_imm[7:0], out_rs1, out_rs2, out_rd,
                     out_funct3, out_funct7b5}),
                64'({ctrl_of(epc), (epc ^ 32'hA5A5_0000) ^ ~epc, 8'(epc + 32'd3), epc[6:2],
                     5'(epc[6:2] + 5'd1), epc[6:2] ^ 5'h1F, epc[4:2], epc[2]}));
            chk({tag, " rd1"}, 64'(out_rd1), 64'(epc ^ 32'hA5A5_0000));
        end else begin
            chk({tag, " bubble ctrl"}, 64'(out_ctrl & 14'h2049), 64'd0);
        end
    endtask

    task automatic add(input logic rst, input logic fl, input logic iv, input logic ordy,
                       input logic [31:0] pc, input logic ev, input logic er,
                       input logic [31:0] epc, input logic [3:0] st);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.ordy = ordy; v.pc = pc;
        v.exp_valid = ev; v.exp_ready = er; v.exp_pc = epc; v.exp_stall = st;
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(32'h0);

        // rst fl iv ordy pc     | valid ready pc     stall
        add(1, 0, 0, 1, 32'h00,    0, 1, 32'h00, 4'd0);
        // Streaming: one per cycle, in_ready stays high
        for (int i = 0; i < 8; i++)
            add(0, 0, 1, 1, 32'(i * 4), 1, 1, 32'(i * 4), 4'd0);
        add(0, 0, 0, 1, 32'h00,    0, 1, 32'h00, 4'd0);
        // Backpressure: 0x44 goes to skid, 0x48 is held upstream until skid drains
        add(0, 0, 1, 1, 32'h40,    1, 1, 32'h40, 4'd0);
        add(0, 0, 1, 0, 32'h44,    1, 0, 32'h40, 4'd1);
        add(0, 0, 1, 0, 32'h48,    1, 0, 32'h40, 4'd2);
        add(0, 0, 1, 0, 32'h48,    1, 0, 32'h40, 4'd3);
        add(0, 0, 1, 1, 32'h48,    1, 1, 32'h44, 4'd3);
        add(0, 0, 1, 1, 32'h48,    1, 1, 32'h48, 4'd3);
        add(0, 0, 0, 1, 32'h00,    0, 1, 32'h00, 4'd3);
        // Flush with both entries full and a new input offered
        add(0, 0, 1, 1, 32'h20,    1, 1, 32'h20, 4'd3);
        add(0, 0, 1, 0, 32'h24,    1, 0, 32'h20, 4'd4);
        add(0, 1, 1, 0, 32'h28,    0, 1, 32'h00, 4'd5);
        add(0, 0, 0, 1, 32'h00,    0, 1, 32'h00, 4'd5);
        add(0, 0, 0, 1, 32'h00,    0, 1, 32'h00, 4'd5);
        add(0, 0, 1, 1, 32'h2C,    1, 1, 32'h2C, 4'd5);
        add(0, 0, 0, 1, 32'h00,    0, 1, 32'h00, 4'd5);
        // Flush while empty and in_ready=1: the offered input is still dropped
        add(0, 1, 1, 1, 32'h34,    0, 1, 32'h00, 4'd5);
        add(0, 0, 0, 1, 32'h00,    0, 1, 32'h00, 4'd5);
        // Reset overrides a concurrent input and clears the counter
        add(1, 0, 1, 0, 32'h30,    0, 1, 32'h00, 4'd0);

        step();
        foreach (vecs[i]) begin
            reset = vecs[i].rst; flush = vecs[i].fl;
            in_valid = vecs[i].iv; out_ready = vecs[i].ordy;
            drive(vecs[i].pc);
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc);
            chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(vecs[i].exp_ready));
            chk($sformatf("vec%0d stall_cnt", i), 64'(stall_cnt), 64'(vecs[i].exp_stall));
        end
        chk("reset out_pc", 64'(out_pc), 64'd0);
        chk("reset out_ctrl", 64'(out_ctrl), 64'd0);

        // Single lw: appears the next cycle, then bubbles with side effects cleared
        reset = 1'b0; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        drive(32'h100);
        in_ctrl = 14'h2090; in_imm = 32'h8;
        step();
        chk("lw out_valid", 64'(out_valid), 64'd1);
        chk("lw out_ctrl", 64'(out_ctrl), 64'h2090);
        chk("lw out_pc", 64'(out_pc), 64'h100);
        chk("lw out_imm", 64'(out_imm), 64'h8);
        in_valid = 1'b0;
        step();
        chk("lw bubble valid", 64'(out_valid), 64'd0);
        chk("lw bubble ctrl", 64'(out_ctrl & 14'h2049), 64'd0);

        // Saturation: 4-bit counter must stop at 15, outputs stay frozen
        out_ready = 1'b0; in_valid = 1'b1;
        drive(32'h60);
        step();
        chk("sat first valid", 64'(out_valid), 64'd1);
        chk("sat first stall", 64'(stall_cnt), 64'd0);
        drive(32'h64);
        step();
        chk("sat skid in_ready", 64'(in_ready), 64'd0);
        chk("sat stall 1", 64'(stall_cnt), 64'd1);
        in_valid = 1'b0;
        for (int i = 2; i < 20; i++) begin
            step();
            chk($sformatf("sat stall %0d", i), 64'(stall_cnt), 64'((i > 15) ? 15 : i));
        end
        chk("sat hold pc", 64'(out_pc), 64'h60);
        chk("sat hold ctrl", 64'(out_ctrl), 64'(ctrl_of(32'h60)));

        // Reset in the middle of a stall
        reset = 1'b1;
        step();
        chk("midreset valid", 64'(out_valid), 64'd0);
        chk("midreset stall", 64'(stall_cnt), 64'd0);
        reset = 1'b0;
        step();
        chk("postreset in_ready", 64'(in_ready), 64'd1);
        chk("postreset valid", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
